// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode/status types and writeback FSM state shared by the datapath
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_PASS = 4'd5,
        ALU_MULT = 4'd6,
        ALU_DIV  = 4'd7
    } control_e;

    // Bit order, MSB first: zero, sign, overflow, div0
    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
        logic div0;
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } wb_state_e;

    // Ops whose 32-bit result needs a second register-file write
    function automatic logic is_wide(input control_e ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: result capture, RF write sequencing, flags
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int RF_ADDR_W = 4,
    parameter int HI_REG    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          alu_out,
    input  status_t              alu_stat,
    input  control_e             alu_ctrl,
    input  logic [RF_ADDR_W-1:0] dest,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [15:0]          rf_wdata,
    output status_t              flags,
    output logic                 ovf_sticky,
    input  logic                 clr_sticky,
    output logic                 exc_div0
);

    wb_state_e              r_state;
    logic [31:0]            r_out_q;
    status_t                r_stat_q;
    control_e               r_ctrl_q;
    logic [RF_ADDR_W-1:0]   r_dest_q;

    logic                   r_in_ready;
    logic                   r_rf_we;
    logic [RF_ADDR_W-1:0]   r_rf_waddr;
    logic [15:0]            r_rf_wdata;
    status_t                r_flags;
    logic                   r_ovf_sticky;
    logic                   r_exc_div0;

    logic                   w_accept;
    logic                   w_in_div0;
    logic                   w_in_goes_hi;
    logic                   w_lo_goes_hi;
    logic                   w_retire;

    // Handshake and decode of the incoming op; outputs for its ST_LO cycle are precomputed here
    always_comb begin
        w_accept     = in_valid && r_in_ready;
        w_in_div0    = (alu_ctrl == ALU_DIV) && alu_stat.div0;
        w_in_goes_hi = is_wide(alu_ctrl) && !alu_stat.div0;
        w_retire     = (r_state == ST_LO);
        w_lo_goes_hi = w_retire && is_wide(r_ctrl_q) && !r_stat_q.div0;
    end

    // Writeback FSM; all outputs are registered so they reflect the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_out_q      <= '0;
            r_stat_q     <= '0;
            r_ctrl_q     <= ALU_ADD;
            r_dest_q     <= '0;
            r_in_ready   <= 1'b1;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_exc_div0   <= 1'b0;
        end else if (w_lo_goes_hi) begin
            // Second write of a wide op: high word to the fixed register, upstream released
            r_state      <= ST_HI;
            r_in_ready   <= 1'b1;
            r_rf_we      <= 1'b1;
            r_rf_waddr   <= RF_ADDR_W'(HI_REG);
            r_rf_wdata   <= r_out_q[31:16];
            r_exc_div0   <= 1'b0;
        end else if (w_accept) begin
            r_state      <= ST_LO;
            r_out_q      <= alu_out;
            r_stat_q     <= alu_stat;
            r_ctrl_q     <= alu_ctrl;
            r_dest_q     <= dest;
            r_in_ready   <= !w_in_goes_hi;
            r_rf_we      <= !w_in_div0;
            r_rf_waddr   <= dest;
            r_rf_wdata   <= alu_out[15:0];
            r_exc_div0   <= w_in_div0;
        end else begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_rf_we      <= 1'b0;
            r_exc_div0   <= 1'b0;
        end
    end

    // Architectural flags and sticky overflow update as the ST_LO cycle retires an op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (w_retire) begin
                r_flags <= r_stat_q;
            end
            if (w_retire && r_stat_q.overflow) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign flags      = r_flags;
    assign ovf_sticky = r_ovf_sticky;
    assign exc_div0   = r_exc_div0;

endmodule
